// File: rtl/booth_mult_arbiter.sv
// Sequential radix-2 Booth multiplier shared by two requesters under round-robin arbitration.
// Latency: done is high WIDTH cycles after the grant edge. Later requests wait while busy (no preemption).
module booth_mult_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               owner
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic             gnt, start, finish;
  logic [WIDTH:0]   m, acc, sum, acc_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             q0;
  logic [CW-1:0]    cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    gnt       = req1 & (~req0 | ~last);
    case (state)
      IDLE: if (req0 | req1) begin
        start     = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt_nxt == '0) begin
        finish    = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One Booth step: conditional add/subtract, then arithmetic shift of {acc,q,q0}.
  always_comb begin
    case ({q[0], q0})
      2'b10:   sum = acc - m;
      2'b01:   sum = acc + m;
      default: sum = acc;
    endcase
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q[WIDTH-1:1]};
    cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last  <= 1'b1;
      owner <= 1'b0;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q0    <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (start) begin
        owner <= gnt;
        last  <= gnt;
        m     <= gnt ? {a1[WIDTH-1], a1} : {a0[WIDTH-1], a0};
        q     <= gnt ? b1 : b0;
        acc   <= '0;
        q0    <= 1'b0;
        cnt   <= CW'(WIDTH);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        q   <= q_nxt;
        q0  <= q[0];
        cnt <= cnt_nxt;
        if (finish) begin
          p     <= {acc_nxt[WIDTH-1:0], q_nxt};
          done0 <= ~owner;
          done1 <= owner;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed and randomized bench for booth_mult_arbiter against a signed-multiply reference.
module tb_booth_mult_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           done0, done1, busy, owner;
  logic [2*W-1:0] p;

  int checks = 0;
  int errors = 0;

  booth_mult_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .p(p), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges until a done pulse is seen at a falling edge; n is the edge count.
  task automatic wait_done(output int n, output logic who);
    n = 0;
    who = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done0 || done1) begin
        who = done1;
        return;
      end
    end
    chk("done_timeout", {31'b0, done0 | done1}, 32'd1);
  endtask

  task automatic step_idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge with the engine idle; returns at a falling edge, idle again.
  task automatic single_op(input logic r, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n;
    logic who;
    if (r) begin a1 = a; b1 = b; req1 = 1'b1; end
    else   begin a0 = a; b0 = b; req0 = 1'b1; end
    wait_done(n, who);
    chk({tag, "_who"}, {31'b0, who}, {31'b0, r});
    chk({tag, "_p"}, {24'b0, p}, {24'b0, ref_mul(a, b)});
    chk({tag, "_lat"}, n, W + 1);
    chk({tag, "_other_done"}, {31'b0, r ? done0 : done1}, 32'd0);
    chk({tag, "_owner"}, {31'b0, owner}, {31'b0, r});
    if (r) req1 = 1'b0; else req0 = 1'b0;
    step_idle();
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic who;
    logic [W-1:0] ea [2];
    logic [W-1:0] eb [2];
    logic [W-1:0] oa, ob;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_p", {24'b0, p}, 32'd0);
    chk("rst_done", {30'b0, done1, done0}, 32'd0);
    chk("rst_owner", {31'b0, owner}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic product and corner values
    single_op(1'b0, 4'h3, 4'hE, "basic");
    single_op(1'b0, 4'h8, 4'h8, "c_88");
    single_op(1'b0, 4'h8, 4'h7, "c_87");
    single_op(1'b0, 4'h7, 4'h7, "c_77");
    single_op(1'b0, 4'h0, 4'h9, "c_09");
    single_op(1'b1, 4'h8, 4'h8, "c1_88");

    // Contention: both held from reset-like state, expect 0,1,0,1 with W+2 spacing
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ea[r] = W'($urandom);
      eb[r] = W'($urandom);
    end
    a0 = ea[0]; b0 = eb[0]; a1 = ea[1]; b1 = eb[1];
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(n, who);
      chk("alt_who", {31'b0, who}, k % 2);
      chk("alt_gap", n, W + 1);
      chk("alt_p", {24'b0, p}, {24'b0, ref_mul(ea[k%2], eb[k%2])});
      chk("alt_excl", {31'b0, done0 & done1}, 32'd0);
      if (who) req1 = 1'b0; else req0 = 1'b0;
      step_idle();
      if (k < 2) begin
        ea[k%2] = W'($urandom);
        eb[k%2] = W'($urandom);
        if (k % 2 == 1) begin a1 = ea[1]; b1 = eb[1]; req1 = 1'b1; end
        else            begin a0 = ea[0]; b0 = eb[0]; req0 = 1'b1; end
      end
    end

    // Operand change mid-RUN, late req1 waits for DONE plus one IDLE cycle
    oa = W'($urandom);
    ob = W'($urandom);
    a0 = oa; b0 = ob; req0 = 1'b1;
    step_idle();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    chk("mid_owner", {31'b0, owner}, 32'd0);
    a0 = ~oa; b0 = ob + 4'd5;
    a1 = W'($urandom_range(1, 7));
    b1 = W'($urandom_range(1, 7));
    req1 = 1'b1;
    wait_done(n, who);
    chk("mid_who0", {31'b0, who}, 32'd0);
    chk("mid_lat0", n, W);
    chk("mid_p0", {24'b0, p}, {24'b0, ref_mul(oa, ob)});
    req0 = 1'b0;
    step_idle();
    wait_done(n, who);
    chk("mid_who1", {31'b0, who}, 32'd1);
    chk("mid_gap1", n, W + 1);
    chk("mid_p1", {24'b0, p}, {24'b0, ref_mul(a1, b1)});
    req1 = 1'b0;
    step_idle();

    // Reset pulse mid-RUN of requester 0 while requester 1 is pending
    oa = W'($urandom);
    ob = W'($urandom);
    a0 = oa; b0 = ob; a1 = W'($urandom); b1 = W'($urandom);
    req0 = 1'b1;
    req1 = 1'b1;
    step_idle();
    step_idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_p", {24'b0, p}, 32'd0);
    chk("rmid_done", {30'b0, done1, done0}, 32'd0);
    #1 rst_n = 1'b1;
    wait_done(n, who);
    chk("rmid_who", {31'b0, who}, 32'd0);
    chk("rmid_lat", n, W + 1);
    chk("rmid_prod", {24'b0, p}, {24'b0, ref_mul(oa, ob)});
    req0 = 1'b0;
    step_idle();
    wait_done(n, who);
    chk("rmid_who1", {31'b0, who}, 32'd1);
    chk("rmid_p1", {24'b0, p}, {24'b0, ref_mul(a1, b1)});
    req1 = 1'b0;
    step_idle();

    // Random single operations on either requester
    for (int i = 0; i < 24; i++) begin
      single_op(1'($urandom), W'($urandom), W'($urandom), "rand");
    end

    // Exhaustive sweep on requester 0
    for (int i = 0; i < (1 << (2 * W)); i++) begin
      oa = W'(i >> W);
      ob = W'(i);
      single_op(1'b0, oa, ob, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Sequential radix-2 Booth multiplier engine shared between two requesters.
- A round-robin arbiter grants the engine to one requester at a time. The engine performs one Booth add/shift step per clock.
- The product is returned with a one-cycle done pulse to the owning requester.
- Replaces the combinational multiplier where area matters more than latency.

Parameters:
- WIDTH, 4, operand width in bits. Both operands and the result are signed two's complement. WIDTH >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request, level, held until done0
- a0  in  WIDTH  requester 0 multiplicand
- b0  in  WIDTH  requester 0 multiplier
- req1  in  1  requester 1 request, level, held until done1
- a1  in  WIDTH  requester 1 multiplicand
- b1  in  WIDTH  requester 1 multiplier
- done0  out  1  one-cycle pulse: p valid for requester 0
- done1  out  1  one-cycle pulse: p valid for requester 1
- p  out  2*WIDTH  signed product, registered, held until next DONE
- busy  out  1  high whenever the state is not IDLE
- owner  out  1  index of the current or most recent grantee

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, done0=done1=0, p=0, busy=0, owner=0.
  - Round-robin pointer last=1, so req0 wins the first contention.
  - All datapath registers clear.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - At a rising edge with any req high, grant and go to RUN.
  - Both high: grant the index != last. Only one high: grant it.
  - On grant: owner=grant, last=grant. Latch M=a_grant, Q=b_grant, acc=0, q0=0, cnt=WIDTH.
  - Operand changes after the grant edge are ignored.
- RUN:
  - One Booth step per edge.
  - {Q[0],q0}=10: acc=acc-M. 01: acc=acc+M. 00/11: no add.
  - Then arithmetic right shift of {acc,Q,q0} by 1, replicating the acc MSB. Then cnt=cnt-1.
  - acc and M are WIDTH+1 bits, with M sign-extended, so M=-2^(WIDTH-1) does not overflow.
  - On the edge where cnt reaches 0: p={acc[WIDTH-1:0],Q}, done_owner=1, go to DONE.
- DONE:
  - done_owner stays high for exactly this one cycle.
  - The next edge clears done and returns to IDLE. No grant is made on that edge.
- Latency and throughput:
  - Grant edge E0; done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the grant.
  - Earliest next grant is edge E_(WIDTH+2). Throughput is one product per WIDTH+2 cycles.
- Handshake:
  - A requester must drop req on the same edge at which it samples done high.
  - A req still high in IDLE is treated as a new request and recomputed.
- Simultaneous events:
  - A req arriving during RUN or DONE waits. No preemption.
  - With both requesters continuously requesting, grants strictly alternate.
- done0 and done1 are never high together. The non-owner's done stays 0.
- Reset mid-RUN aborts the operation: no done pulse, p=0, and after release the FSM is in IDLE.
- p holds its value through IDLE and RUN until the next DONE overwrites it.

Test Plan:
- Reset then req0=1 with a0=4'h3, b0=4'hE -> done0 pulses 4 cycles after the grant edge, p=8'hFA (-6), done1 stays 0, owner=0.
- Corner values: a0=4'h8, b0=4'h8 -> p=8'h40. a0=4'h8, b0=4'h7 -> p=8'hC8. a0=4'h7, b0=4'h7 -> p=8'h31. a0=4'h0, b0=4'h9 -> p=8'h00.
- req0 and req1 asserted on the same edge after reset, held until their done:
  - Requester 0 is served first; requester 1 is granted 6 cycles after requester 0's grant.
  - Then grants alternate 0,1,0,1 over four operations with correct products each time.
- req1 rises while requester 0 is in RUN; change a0/b0 mid-RUN -> the requester 0 result uses the latched operands, and requester 1 is granted on the edge after DONE plus one IDLE cycle.
- rst_n pulsed low for a partial cycle during RUN -> immediately busy=0, p=0, no done. With req held, the next grant goes to req0 and gives the correct product.
- Exhaustive sweep of all 256 WIDTH=4 signed pairs on requester 0 -> every p equals the a*b signed reference model.
